// File: rtl/pulse_qualifier.sv
// pulse_qualifier
//   Synchronises an asynchronous request pulse, rejects glitches shorter than
//   MINLEN clock cycles and emits one clean OUTLEN-cycle output pulse for each
//   qualified assertion. A held input produces a single pulse and must drop
//   before the block can trigger again.
//
//   Optional build macro: PULSE_QUALIFIER_GLITCH_CNT_EN
//     defined   -> glitch_cnt port and a 16-bit saturating count of rejected
//                  glitches (QUAL aborted because the input fell)
//     undefined -> no glitch_cnt port, no counter; FSM behaviour is identical
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for the synchronised input to become active
//   QUAL  | input active, counting consecutive active cycles up to MINLEN
//   OUT   | driving pulse_o active for exactly OUTLEN cycles, input ignored
//   REARM | pulse finished while input still active; wait for it to drop
module pulse_qualifier #(
    parameter int   SYNC   = 2,
    parameter int   MINLEN = 4,
    parameter int   OUTLEN = 10,
    parameter logic IPOL   = 1'b1,
    parameter logic OPOL   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pulse_i,
    output logic        pulse_o,
    output logic        detect,
    output logic        busy
`ifdef PULSE_QUALIFIER_GLITCH_CNT_EN
    ,
    output logic [15:0] glitch_cnt
`endif
);

    // Counter widths sized so the terminal value fits without wrapping.
    localparam int QW = $clog2(MINLEN + 1);
    localparam int OW = $clog2(OUTLEN + 1);

    // qcnt holds the number of active cycles already seen; qualification
    // completes on the cycle where one more active sample reaches MINLEN.
    localparam logic [QW-1:0] QLAST = QW'(MINLEN - 1);
    localparam logic [OW-1:0] OLAST = OW'(OUTLEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUAL  = 2'd1,
        ST_OUT   = 2'd2,
        ST_REARM = 2'd3
    } state_t;

    // Elaboration-time guard against unusable parameter values.
    generate
        if (SYNC < 2) begin : g_bad_sync
            $error("pulse_qualifier: SYNC must be >= 2");
        end
        if (MINLEN < 1) begin : g_bad_minlen
            $error("pulse_qualifier: MINLEN must be >= 1");
        end
        if (OUTLEN < 1) begin : g_bad_outlen
            $error("pulse_qualifier: OUTLEN must be >= 1");
        end
    endgenerate

    logic [SYNC-1:0] sync_q;
    logic            in_s;

    state_t          state_q;
    state_t          state_d;
    logic [QW-1:0]   qcnt_q;
    logic [QW-1:0]   qcnt_d;
    logic [OW-1:0]   ocnt_q;
    logic [OW-1:0]   ocnt_d;

    logic            pulse_q;
    logic            detect_q;
    logic            busy_q;

    // Plain shift-register synchroniser; resets to the inactive level so a
    // reset release never looks like an input assertion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC{~IPOL}};
        end else begin
            sync_q <= {sync_q[SYNC-2:0], pulse_i};
        end
    end

    assign in_s = (sync_q[SYNC-1] == IPOL);

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            qcnt_q  <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            ocnt_q  <= ocnt_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        ocnt_d  = ocnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_s) begin
                    if (MINLEN == 1) begin
                        state_d = ST_OUT;
                        ocnt_d  = OW'(1);
                    end else begin
                        state_d = ST_QUAL;
                        qcnt_d  = QW'(1);
                    end
                end
            end
            ST_QUAL: begin
                if (in_s) begin
                    if (qcnt_q == QLAST) begin
                        state_d = ST_OUT;
                        qcnt_d  = '0;
                        ocnt_d  = OW'(1);
                    end else begin
                        qcnt_d  = qcnt_q + QW'(1);
                    end
                end else begin
                    state_d = ST_IDLE;
                    qcnt_d  = '0;
                end
            end
            ST_OUT: begin
                // ocnt numbers the current OUT cycle, 1..OUTLEN.
                if (ocnt_q == OLAST) begin
                    ocnt_d  = '0;
                    state_d = in_s ? ST_REARM : ST_IDLE;
                end else begin
                    ocnt_d  = ocnt_q + OW'(1);
                end
            end
            ST_REARM: begin
                if (!in_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                qcnt_d  = '0;
                ocnt_d  = '0;
            end
        endcase
    end

    // Outputs registered from next-state so they are glitch-free and line up
    // with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_q  <= ~OPOL;
            detect_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            pulse_q  <= (state_d == ST_OUT) ? OPOL : ~OPOL;
            detect_q <= (state_d == ST_OUT) && (state_q != ST_OUT);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign pulse_o = pulse_q;
    assign detect  = detect_q;
    assign busy    = busy_q;

`ifdef PULSE_QUALIFIER_GLITCH_CNT_EN
    logic        glitch_ev;
    logic [15:0] glitch_cnt_q;

    assign glitch_ev = (state_q == ST_QUAL) && !in_s;

    // Saturating count of qualifications aborted by the input falling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_cnt_q <= '0;
        end else if (glitch_ev && (glitch_cnt_q != 16'hFFFF)) begin
            glitch_cnt_q <= glitch_cnt_q + 16'd1;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`else
    // No glitch statistics in this build; the FSM is unaffected.
`endif

endmodule

// File: tb/tb_pulse_qualifier.sv
// Testbench for pulse_qualifier. Two instances: A uses the default
// parameters, B is active-low on both sides with MINLEN=1 and SYNC=3.
// Expected waveforms come from a run-length model of the input sequence.
module tb_pulse_qualifier;

    localparam int MAXN   = 160;
    localparam int A_SYNC = 2;
    localparam int A_MIN  = 4;
    localparam int A_OUT  = 10;
    localparam int B_SYNC = 3;
    localparam int B_MIN  = 1;
    localparam int B_OUT  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic pin_a = 1'b0;
    logic pin_b = 1'b1;
    logic po_a, det_a, busy_a;
    logic po_b, det_b, busy_b;
`ifdef PULSE_QUALIFIER_GLITCH_CNT_EN
    logic [15:0] gc_a, gc_b;
`endif

    always #5 clk = ~clk;

    pulse_qualifier #(.SYNC(A_SYNC), .MINLEN(A_MIN), .OUTLEN(A_OUT),
                      .IPOL(1'b1), .OPOL(1'b1)) dut_a (
        .clk(clk), .reset(reset), .pulse_i(pin_a),
        .pulse_o(po_a), .detect(det_a), .busy(busy_a)
`ifdef PULSE_QUALIFIER_GLITCH_CNT_EN
        , .glitch_cnt(gc_a)
`endif
    );

    pulse_qualifier #(.SYNC(B_SYNC), .MINLEN(B_MIN), .OUTLEN(B_OUT),
                      .IPOL(1'b0), .OPOL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .pulse_i(pin_b),
        .pulse_o(po_b), .detect(det_b), .busy(busy_b)
`ifdef PULSE_QUALIFIER_GLITCH_CNT_EN
        , .glitch_cnt(gc_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    bit              stim [MAXN];
    logic [MAXN-1:0] obs_po, obs_det, obs_busy;
    logic [MAXN-1:0] exp_po, exp_det, exp_busy;
    int              exp_glitch;

    // Reset both instances, release, then apply stim[0..n-1] (1 = active
    // level) to the chosen instance, one value per clock edge. Outputs are
    // captured 1 time unit after each edge, normalised to 1 = active.
    task automatic run_scenario(input int which, input int n);
        reset = 1'b1;
        pin_a = 1'b0;
        pin_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        obs_po   = '0;
        obs_det  = '0;
        obs_busy = '0;
        reset    = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (which == 0) pin_a = stim[k];
            else            pin_b = ~stim[k];
            @(posedge clk);
            #1;
            if (which == 0) begin
                obs_po[k]   = po_a;
                obs_det[k]  = det_a;
                obs_busy[k] = busy_a;
            end else begin
                obs_po[k]   = ~po_b;
                obs_det[k]  = det_b;
                obs_busy[k] = busy_b;
            end
        end
    endtask

    // Reference: the FSM sees at edge t the input driven for edge t-SYNC.
    // Scan runs of active samples: a run reaching MINLEN yields a pulse on
    // edges q..q+OUTLEN-1 (q = run start + MINLEN-1); the block is busy
    // until the first inactive sample at or after q+OUTLEN. Shorter runs
    // that end inside the window are glitches.
    task automatic compute_expected(input int which, input int n);
        int sy, ml, ol, t, start, len, q, y;
        bit s [MAXN];
        sy = (which == 0) ? A_SYNC : B_SYNC;
        ml = (which == 0) ? A_MIN  : B_MIN;
        ol = (which == 0) ? A_OUT  : B_OUT;
        for (int i = 0; i < MAXN; i++) s[i] = (i >= sy) ? stim[i - sy] : 1'b0;
        exp_po = '0; exp_det = '0; exp_busy = '0; exp_glitch = 0;
        t = 0;
        while (t < n) begin
            if (!s[t]) begin
                t++;
            end else begin
                start = t;
                len = 0;
                while (start + len < n && s[start + len] && len < ml) len++;
                if (len == ml) begin
                    q = start + ml - 1;
                    for (int i = 0; i < ol; i++) if (q + i < n) exp_po[q + i] = 1'b1;
                    if (q < n) exp_det[q] = 1'b1;
                    y = q + ol;
                    while (y < n && s[y]) y++;
                    for (int i = start; i < y && i < n; i++) exp_busy[i] = 1'b1;
                    t = y + 1;
                end else if (start + len < n) begin
                    exp_glitch++;
                    for (int i = start; i < start + len; i++) exp_busy[i] = 1'b1;
                    t = start + len;
                end else begin
                    for (int i = start; i < n; i++) exp_busy[i] = 1'b1;
                    t = n;
                end
            end
        end
    endtask

    function automatic int first_diff();
        for (int i = 0; i < MAXN; i++)
            if (obs_po[i] !== exp_po[i] || obs_det[i] !== exp_det[i] ||
                obs_busy[i] !== exp_busy[i]) return i;
        return -1;
    endfunction

    function automatic int count_ones(input logic [MAXN-1:0] v);
        int c = 0;
        for (int i = 0; i < MAXN; i++) if (v[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_one(input logic [MAXN-1:0] v);
        for (int i = 0; i < MAXN; i++) if (v[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int rising_edges(input logic [MAXN-1:0] v);
        int c = 0;
        for (int i = 0; i < MAXN; i++)
            if (v[i] === 1'b1 && (i == 0 || v[i-1] !== 1'b1)) c++;
        return c;
    endfunction

    task automatic test_reset();
        int d;
        reset = 1'b1;
        pin_a = 1'b1;
        pin_b = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        d = {po_a, det_a, busy_a, po_b, det_b, busy_b};
        checks++;
        if ({po_a, det_a, busy_a} !== 3'b000) begin
            errors++;
            $display("FAIL reset_a po/det/busy got %b%b%b want 000", po_a, det_a, busy_a);
        end
        checks++;
        if ({po_b, det_b, busy_b} !== 3'b100) begin
            errors++;
            $display("FAIL reset_b po/det/busy got %b%b%b want 100", po_b, det_b, busy_b);
        end
`ifdef PULSE_QUALIFIER_GLITCH_CNT_EN
        checks++;
        if (gc_a !== 16'd0 || gc_b !== 16'd0) begin
            errors++;
            $display("FAIL reset_glitch_cnt got %0d/%0d want 0/0", gc_a, gc_b);
        end
`endif
        if (d < 0) $display("unreachable");
    endtask

    task automatic test_basic();
        int idx;
        for (int i = 0; i < MAXN; i++) stim[i] = (i < 20);
        run_scenario(0, 40);
        compute_expected(0, 40);
        checks++;
        if ({obs_po, obs_det, obs_busy} !== {exp_po, exp_det, exp_busy}) begin
            errors++;
            idx = first_diff();
            $display("FAIL basic cycle %0d po/det/busy got %b%b%b want %b%b%b", idx,
                     obs_po[idx], obs_det[idx], obs_busy[idx], exp_po[idx], exp_det[idx], exp_busy[idx]);
        end
        checks++;
        if (first_one(obs_po) !== A_SYNC + A_MIN - 1) begin
            errors++;
            $display("FAIL basic_latency got edge %0d want %0d", first_one(obs_po), A_SYNC + A_MIN - 1);
        end
        checks++;
        if (count_ones(obs_po) !== A_OUT || count_ones(obs_det) !== 1) begin
            errors++;
            $display("FAIL basic_len pulse %0d detect %0d want %0d and 1",
                     count_ones(obs_po), count_ones(obs_det), A_OUT);
        end
    endtask

    task automatic test_glitch();
        int idx;
        for (int i = 0; i < MAXN; i++) stim[i] = (i < 3);
        run_scenario(0, 30);
        compute_expected(0, 30);
        checks++;
        if ({obs_po, obs_det, obs_busy} !== {exp_po, exp_det, exp_busy}) begin
            errors++;
            idx = first_diff();
            $display("FAIL glitch cycle %0d po/det/busy got %b%b%b want %b%b%b", idx,
                     obs_po[idx], obs_det[idx], obs_busy[idx], exp_po[idx], exp_det[idx], exp_busy[idx]);
        end
        checks++;
        if (count_ones(obs_po) !== 0) begin
            errors++;
            $display("FAIL glitch_nopulse got %0d active cycles want 0", count_ones(obs_po));
        end
`ifdef PULSE_QUALIFIER_GLITCH_CNT_EN
        checks++;
        if (gc_a !== 16'(exp_glitch)) begin
            errors++;
            $display("FAIL glitch_cnt got %0d want %0d", gc_a, exp_glitch);
        end
`endif
    endtask

    task automatic test_held();
        int idx;
        for (int i = 0; i < MAXN; i++) stim[i] = (i < 100) || (i >= 110 && i < 140);
        run_scenario(0, 160);
        compute_expected(0, 160);
        checks++;
        if ({obs_po, obs_det, obs_busy} !== {exp_po, exp_det, exp_busy}) begin
            errors++;
            idx = first_diff();
            $display("FAIL held cycle %0d po/det/busy got %b%b%b want %b%b%b", idx,
                     obs_po[idx], obs_det[idx], obs_busy[idx], exp_po[idx], exp_det[idx], exp_busy[idx]);
        end
        checks++;
        if (rising_edges(obs_po) !== 2 || count_ones(obs_po) !== 2 * A_OUT) begin
            errors++;
            $display("FAIL held_count got %0d pulses %0d cycles want 2 pulses %0d cycles",
                     rising_edges(obs_po), count_ones(obs_po), 2 * A_OUT);
        end
        checks++;
        if (obs_busy[100 + A_SYNC - 1] !== 1'b1 || obs_busy[100 + A_SYNC] !== 1'b0) begin
            errors++;
            $display("FAIL held_busy got %b%b around input fall want 10",
                     obs_busy[100 + A_SYNC - 1], obs_busy[100 + A_SYNC]);
        end
    endtask

    task automatic test_drop_in_out();
        int idx;
        for (int i = 0; i < MAXN; i++) stim[i] = (i < A_MIN);
        run_scenario(0, 30);
        compute_expected(0, 30);
        checks++;
        if ({obs_po, obs_det, obs_busy} !== {exp_po, exp_det, exp_busy}) begin
            errors++;
            idx = first_diff();
            $display("FAIL drop cycle %0d po/det/busy got %b%b%b want %b%b%b", idx,
                     obs_po[idx], obs_det[idx], obs_busy[idx], exp_po[idx], exp_det[idx], exp_busy[idx]);
        end
        checks++;
        if (count_ones(obs_po) !== A_OUT || obs_busy[29] !== 1'b0) begin
            errors++;
            $display("FAIL drop_len got %0d cycles busy_end %b want %0d and 0",
                     count_ones(obs_po), obs_busy[29], A_OUT);
        end
    endtask

    task automatic test_reset_mid();
        int idx;
        for (int i = 0; i < MAXN; i++) stim[i] = 1'b1;
        // Edge 9 is the fifth OUT cycle: pulse starts at edge SYNC+MINLEN-1 = 5.
        run_scenario(0, 10);
        checks++;
        if (obs_po[9] !== 1'b1 || obs_busy[9] !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre po/busy got %b%b want 11", obs_po[9], obs_busy[9]);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({po_a, det_a, busy_a} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset po/det/busy got %b%b%b want 000", po_a, det_a, busy_a);
        end
        run_scenario(0, 30);
        compute_expected(0, 30);
        checks++;
        if ({obs_po, obs_det, obs_busy} !== {exp_po, exp_det, exp_busy}) begin
            errors++;
            idx = first_diff();
            $display("FAIL mid_after cycle %0d po/det/busy got %b%b%b want %b%b%b", idx,
                     obs_po[idx], obs_det[idx], obs_busy[idx], exp_po[idx], exp_det[idx], exp_busy[idx]);
        end
    endtask

    task automatic test_inverted();
        int idx;
        for (int i = 0; i < MAXN; i++) stim[i] = (i == 3);
        run_scenario(1, 40);
        compute_expected(1, 40);
        checks++;
        if ({obs_po, obs_det, obs_busy} !== {exp_po, exp_det, exp_busy}) begin
            errors++;
            idx = first_diff();
            $display("FAIL inverted cycle %0d po/det/busy got %b%b%b want %b%b%b", idx,
                     obs_po[idx], obs_det[idx], obs_busy[idx], exp_po[idx], exp_det[idx], exp_busy[idx]);
        end
        checks++;
        if (count_ones(obs_po) !== B_OUT || first_one(obs_po) !== 3 + B_SYNC + B_MIN - 1) begin
            errors++;
            $display("FAIL inverted_len got %0d cycles from %0d want %0d from %0d",
                     count_ones(obs_po), first_one(obs_po), B_OUT, 3 + B_SYNC + B_MIN - 1);
        end
    endtask

    task automatic test_random();
        int idx, k, ones, zeros, which;
        for (int r = 0; r < 8; r++) begin
            which = r % 2;
            k = 0;
            while (k < MAXN) begin
                ones  = $urandom_range(1, 14);
                zeros = $urandom_range(1, 8);
                for (int i = 0; i < ones && k < MAXN; i++) stim[k++] = 1'b1;
                for (int i = 0; i < zeros && k < MAXN; i++) stim[k++] = 1'b0;
            end
            run_scenario(which, MAXN);
            compute_expected(which, MAXN);
            checks++;
            if ({obs_po, obs_det, obs_busy} !== {exp_po, exp_det, exp_busy}) begin
                errors++;
                idx = first_diff();
                $display("FAIL random%0d dut%0d cycle %0d po/det/busy got %b%b%b want %b%b%b", r, which, idx,
                         obs_po[idx], obs_det[idx], obs_busy[idx], exp_po[idx], exp_det[idx], exp_busy[idx]);
            end
`ifdef PULSE_QUALIFIER_GLITCH_CNT_EN
            checks++;
            if (((which == 0) ? gc_a : gc_b) !== 16'(exp_glitch)) begin
                errors++;
                $display("FAIL random%0d_glitch_cnt got %0d want %0d", r,
                         (which == 0) ? gc_a : gc_b, exp_glitch);
            end
`endif
        end
    endtask

    task automatic test_many_glitches();
        int ones, zeros, active;
        for (int i = 0; i < MAXN; i++) stim[i] = 1'b0;
        run_scenario(0, 1);
        active = 0;
        for (int g = 0; g < 300; g++) begin
            ones  = $urandom_range(1, A_MIN - 1);
            zeros = $urandom_range(1, 3);
            for (int i = 0; i < ones + zeros; i++) begin
                pin_a = (i < ones);
                @(posedge clk);
                #1;
                if (po_a === 1'b1) active++;
            end
        end
        pin_a = 1'b0;
        repeat (A_SYNC + 2) @(posedge clk);
        #1;
        checks++;
        if (active !== 0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL glitch_train pulse cycles %0d busy %b want 0 and 0", active, busy_a);
        end
`ifdef PULSE_QUALIFIER_GLITCH_CNT_EN
        checks++;
        if (gc_a !== 16'd300) begin
            errors++;
            $display("FAIL glitch_train_cnt got %0d want 300", gc_a);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_held();
        test_drop_in_out();
        test_reset_mid();
        test_inverted();
        test_random();
        test_many_glitches();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
